// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter for the SDRAM port: video reader vs CPU; 1-cycle grant latency, zero-latency response routing.
// Backpressure: waitrequest to the ungranted master, and to a granted read while the tag FIFO is full (a same-cycle pop frees a slot).
module sdram_port_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BE_W      = 2,
    parameter int MAX_PEND  = 8,
    parameter int VID_BURST = 16
) (
    input  logic                        clk_50,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           vid_address,
    input  logic                        vid_read,
    output logic                        vid_waitrequest,
    output logic [DATA_W-1:0]           vid_readdata,
    output logic                        vid_readdatavalid,
    input  logic [ADDR_W-1:0]           cpu_address,
    input  logic                        cpu_read,
    input  logic                        cpu_write,
    input  logic [DATA_W-1:0]           cpu_writedata,
    input  logic [BE_W-1:0]             cpu_byteenable,
    output logic                        cpu_waitrequest,
    output logic [DATA_W-1:0]           cpu_readdata,
    output logic                        cpu_readdatavalid,
    output logic [ADDR_W-1:0]           sdr_address,
    output logic                        sdr_read,
    output logic                        sdr_write,
    output logic [DATA_W-1:0]           sdr_writedata,
    output logic [BE_W-1:0]             sdr_byteenable,
    input  logic                        sdr_waitrequest,
    input  logic [DATA_W-1:0]           sdr_readdata,
    input  logic                        sdr_readdatavalid,
    output logic [$clog2(MAX_PEND):0]   pend_cnt,
    output logic                        err
);

    localparam int PTR_W = $clog2(MAX_PEND);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(VID_BURST + 1);

    localparam logic [CNT_W-1:0] PEND_MAX   = CNT_W'(MAX_PEND);
    localparam logic [BC_W-1:0]  BURST_MAX  = BC_W'(VID_BURST);
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(VID_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID,
        ST_CPU
    } state_t;

    state_t             r_state;
    logic [BC_W-1:0]    r_bcnt;
    logic [MAX_PEND-1:0] r_tag;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_pend_cnt;
    logic               r_err;

    logic w_vid_gnt;
    logic w_cpu_gnt;
    logic w_cpu_req;
    logic w_empty;
    logic w_pop;
    logic w_full;
    logic w_acc;
    logic w_push;
    logic w_vid_acc;
    logic w_bcnt_hit;
    logic w_head;

    assign w_vid_gnt = (r_state == ST_VID) & ~reset;
    assign w_cpu_gnt = (r_state == ST_CPU) & ~reset;
    assign w_cpu_req = cpu_read | cpu_write;

    // A response popping this cycle frees its slot for a read issued in the same cycle.
    assign w_empty = (r_pend_cnt == '0);
    assign w_pop   = sdr_readdatavalid & ~w_empty & ~reset;
    assign w_full  = (r_pend_cnt == PEND_MAX) & ~w_pop;

    assign sdr_read       = ((w_vid_gnt & vid_read) | (w_cpu_gnt & cpu_read)) & ~w_full;
    assign sdr_write      = w_cpu_gnt & cpu_write;
    assign sdr_address    = w_cpu_gnt ? cpu_address : vid_address;
    assign sdr_writedata  = cpu_writedata;
    assign sdr_byteenable = w_cpu_gnt ? cpu_byteenable : {BE_W{1'b1}};

    assign vid_waitrequest = ~w_vid_gnt | sdr_waitrequest | (vid_read & w_full);
    assign cpu_waitrequest = ~w_cpu_gnt | sdr_waitrequest | (cpu_read & w_full);

    assign w_acc     = (sdr_read | sdr_write) & ~sdr_waitrequest;
    assign w_push    = w_acc & sdr_read;
    assign w_vid_acc = w_acc & w_vid_gnt;

    // Burst limit is reached either already, or by the video command accepted right now.
    assign w_bcnt_hit = (r_bcnt == BURST_MAX) | (w_vid_acc & (r_bcnt == BURST_LAST));

    assign w_head            = r_tag[r_rptr];
    assign vid_readdata      = sdr_readdata;
    assign cpu_readdata      = sdr_readdata;
    assign vid_readdatavalid = w_pop & ~w_head;
    assign cpu_readdatavalid = w_pop & w_head;

    assign pend_cnt = r_pend_cnt;
    assign err      = r_err;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_bcnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (vid_read) begin
                        r_state <= ST_VID;
                        r_bcnt  <= '0;
                    end else if (w_cpu_req) begin
                        r_state <= ST_CPU;
                    end
                end
                ST_VID: begin
                    if (w_vid_acc && (r_bcnt != BURST_MAX)) begin
                        r_bcnt <= r_bcnt + BC_W'(1);
                    end
                    if (w_bcnt_hit && w_cpu_req) begin
                        r_state <= ST_CPU;
                    end else if (!vid_read) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CPU: begin
                    // One accepted command per CPU grant, then video gets first look.
                    if (w_acc) begin
                        if (vid_read) begin
                            r_state <= ST_VID;
                            r_bcnt  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (!w_cpu_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_pend_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_cpu_gnt;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_pend_cnt <= r_pend_cnt + CNT_W'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - CNT_W'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
            if (sdr_readdatavalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a latency-programmable SDRAM responder model.
module tb_sdram_port_arbiter;

    logic        clk_50 = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] vid_address = '0;
    logic        vid_read = 1'b0;
    logic        vid_waitrequest;
    logic [15:0] vid_readdata;
    logic        vid_readdatavalid;
    logic [23:0] cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_writedata = '0;
    logic [1:0]  cpu_byteenable = '0;
    logic        cpu_waitrequest;
    logic [15:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [23:0] sdr_address;
    logic        sdr_read;
    logic        sdr_write;
    logic [15:0] sdr_writedata;
    logic [1:0]  sdr_byteenable;
    logic        sdr_waitrequest = 1'b0;
    logic [15:0] sdr_readdata;
    logic        sdr_readdatavalid;
    logic [3:0]  pend_cnt;
    logic        err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 3;
    int resp_budget = 1000000;
    int pend_peak = 0;
    logic        m_rdv = 1'b0;
    logic        resp_vld = 1'b0;
    logic [15:0] resp_dat = '0;

    int          q_due[$];
    logic [15:0] q_dat[$];
    logic [15:0] vid_log[$];
    logic [15:0] cpu_log[$];
    logic        order_log[$];
    logic [23:0] acc_addr[$];

    assign sdr_readdatavalid = m_rdv | resp_vld;
    assign sdr_readdata      = resp_dat;

    always #5 clk_50 = ~clk_50;

    sdram_port_arbiter dut (
        .clk_50(clk_50), .reset(reset),
        .vid_address(vid_address), .vid_read(vid_read), .vid_waitrequest(vid_waitrequest),
        .vid_readdata(vid_readdata), .vid_readdatavalid(vid_readdatavalid),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .cpu_readdatavalid(cpu_readdatavalid),
        .sdr_address(sdr_address), .sdr_read(sdr_read), .sdr_write(sdr_write),
        .sdr_writedata(sdr_writedata), .sdr_byteenable(sdr_byteenable),
        .sdr_waitrequest(sdr_waitrequest), .sdr_readdata(sdr_readdata),
        .sdr_readdatavalid(sdr_readdatavalid),
        .pend_cnt(pend_cnt), .err(err)
    );

    function automatic logic [15:0] fdat(input logic [23:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // Controller model and output monitor in one process: respond after the posedge, observe at the negedge.
    always begin
        @(posedge clk_50);
        cyc++;
        #2;
        if (reset) begin
            q_due.delete();
            q_dat.delete();
            resp_vld = 1'b0;
        end else if (resp_budget > 0 && q_due.size() > 0 && q_due[0] <= cyc) begin
            resp_vld = 1'b1;
            resp_dat = q_dat.pop_front();
            void'(q_due.pop_front());
            resp_budget--;
        end else begin
            resp_vld = 1'b0;
        end
        @(negedge clk_50);
        if (!reset) begin
            if ((sdr_read || sdr_write) && !sdr_waitrequest) begin
                acc_addr.push_back(sdr_address);
                if (sdr_read) begin
                    q_due.push_back(cyc + lat);
                    q_dat.push_back(fdat(sdr_address));
                end
            end
            if (vid_readdatavalid) vid_log.push_back(vid_readdata);
            if (cpu_readdatavalid) cpu_log.push_back(cpu_readdata);
            if (vid_readdatavalid || cpu_readdatavalid) order_log.push_back(cpu_readdatavalid);
            if (int'(pend_cnt) > pend_peak) pend_peak = int'(pend_cnt);
        end
    end

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic clear_logs();
        vid_log.delete();
        cpu_log.delete();
        order_log.delete();
        acc_addr.delete();
        pend_peak = 0;
    endtask

    task automatic vid_master(input int n, input logic [23:0] base);
        logic got;
        for (int i = 0; i < n; i++) begin
            vid_read    = 1'b1;
            vid_address = base + 24'(i);
            got = 1'b0;
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk_50);
                got = !vid_waitrequest;
                step();
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL vid_master_timeout addr=%0h accepted=0 required=1", vid_address);
                vid_read = 1'b0;
                return;
            end
        end
        vid_read = 1'b0;
    endtask

    task automatic cpu_master(input logic rd, input logic [23:0] a, input logic [15:0] d,
                              input logic [1:0] be);
        logic got;
        cpu_read       = rd;
        cpu_write      = !rd;
        cpu_address    = a;
        cpu_writedata  = d;
        cpu_byteenable = be;
        got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk_50);
            got = !cpu_waitrequest;
            step();
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL cpu_master_timeout addr=%0h accepted=0 required=1", a); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        @(negedge clk_50);
        total++; if (sdr_read !== 1'b0) begin bad++; $display("FAIL rst_sdr_read got=%b exp=0", sdr_read); end
        total++; if (sdr_write !== 1'b0) begin bad++; $display("FAIL rst_sdr_write got=%b exp=0", sdr_write); end
        total++; if (vid_readdatavalid !== 1'b0 || cpu_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b%b exp=00", vid_readdatavalid, cpu_readdatavalid); end
        step();
        reset = 1'b0;
        @(negedge clk_50);
        total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL rst_pend got=%0d exp=0", pend_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (vid_waitrequest !== 1'b1 || cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait got=%b%b exp=11", vid_waitrequest, cpu_waitrequest); end
        step();
    endtask

    task automatic test_cpu_write();
        clear_logs();
        cpu_write = 1'b1; cpu_address = 24'h000010; cpu_writedata = 16'hBEEF; cpu_byteenable = 2'b11;
        @(negedge clk_50);
        total++; if (sdr_write !== 1'b0 || cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL wr_arb_cycle got=%b%b exp=01", sdr_write, cpu_waitrequest); end
        step();
        @(negedge clk_50);
        total++; if (sdr_write !== 1'b1 || sdr_read !== 1'b0) begin bad++; $display("FAIL wr_cmd got=%b%b exp=10", sdr_write, sdr_read); end
        total++; if (sdr_address !== 24'h000010) begin bad++; $display("FAIL wr_addr got=%0h exp=10", sdr_address); end
        total++; if (sdr_writedata !== 16'hBEEF) begin bad++; $display("FAIL wr_data got=%0h exp=beef", sdr_writedata); end
        total++; if (sdr_byteenable !== 2'b11) begin bad++; $display("FAIL wr_be got=%b exp=11", sdr_byteenable); end
        total++; if (cpu_waitrequest !== 1'b0 || vid_waitrequest !== 1'b1) begin bad++; $display("FAIL wr_wait got=%b%b exp=01", cpu_waitrequest, vid_waitrequest); end
        step();
        cpu_write = 1'b0;
        @(negedge clk_50);
        total++; if (sdr_write !== 1'b0 || cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL wr_idle got=%b%b exp=01", sdr_write, cpu_waitrequest); end
        total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL wr_pend got=%0d exp=0", pend_cnt); end
        total++; if (acc_addr.size() != 1) begin bad++; $display("FAIL wr_accepts got=%0d exp=1", acc_addr.size()); end
        step();
    endtask

    task automatic test_vid_reads();
        clear_logs();
        lat = 3;
        vid_master(4, 24'h000100);
        repeat (8) step();
        total++; if (pend_peak != 3) begin bad++; $display("FAIL vid4_peak got=%0d exp=3", pend_peak); end
        total++; if (vid_log.size() != 4) begin bad++; $display("FAIL vid4_count got=%0d exp=4", vid_log.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (vid_log[i] !== fdat(24'h000100 + 24'(i))) begin bad++; $display("FAIL vid4_data[%0d] got=%0h exp=%0h", i, vid_log[i], fdat(24'h000100 + 24'(i))); end
        end
        total++; if (cpu_log.size() != 0) begin bad++; $display("FAIL vid4_cpu_rdv got=%0d exp=0", cpu_log.size()); end
        total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL vid4_drain got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_preempt();
        clear_logs();
        lat = 3;
        fork
            vid_master(40, 24'h000200);
            begin
                repeat (5) step();
                cpu_master(1'b1, 24'h000300, 16'h0000, 2'b11);
            end
        join
        repeat (10) step();
        total++; if (acc_addr.size() != 41) begin bad++; $display("FAIL pre_accepts got=%0d exp=41", acc_addr.size()); end
        total++; if (acc_addr[15] !== 24'h00020F) begin bad++; $display("FAIL pre_acc15 got=%0h exp=20f", acc_addr[15]); end
        total++; if (acc_addr[16] !== 24'h000300) begin bad++; $display("FAIL pre_acc16 got=%0h exp=300", acc_addr[16]); end
        total++; if (acc_addr[17] !== 24'h000210) begin bad++; $display("FAIL pre_acc17 got=%0h exp=210", acc_addr[17]); end
        total++; if (order_log[15] !== 1'b0 || order_log[16] !== 1'b1 || order_log[17] !== 1'b0) begin bad++; $display("FAIL pre_order got=%b%b%b exp=010", order_log[15], order_log[16], order_log[17]); end
        total++; if (cpu_log.size() != 1 || cpu_log[0] !== fdat(24'h000300)) begin bad++; $display("FAIL pre_cpu_data n=%0d got=%0h exp=%0h", cpu_log.size(), cpu_log[0], fdat(24'h000300)); end
        total++; if (vid_log.size() != 40 || vid_log[16] !== fdat(24'h000210)) begin bad++; $display("FAIL pre_vid_data n=%0d got=%0h exp=%0h", vid_log.size(), vid_log[16], fdat(24'h000210)); end
    endtask

    task automatic test_full();
        int t;
        clear_logs();
        lat = 1;
        resp_budget = 0;
        fork
            vid_master(10, 24'h000400);
            begin
                t = 0;
                while (pend_cnt != 4'd8 && t < 50) begin
                    step();
                    @(negedge clk_50);
                    t++;
                end
                total++; if (t >= 50) begin bad++; $display("FAIL full_reach got=%0d exp=8", pend_cnt); end
                step();
                @(negedge clk_50);
                total++; if (sdr_read !== 1'b0 || vid_waitrequest !== 1'b1) begin bad++; $display("FAIL full_stall got=%b%b exp=01", sdr_read, vid_waitrequest); end
                total++; if (acc_addr.size() != 8) begin bad++; $display("FAIL full_accepts got=%0d exp=8", acc_addr.size()); end
                step();
                resp_budget = 1;
                @(negedge clk_50);
                total++; if (vid_readdatavalid !== 1'b1 || sdr_read !== 1'b1 || vid_waitrequest !== 1'b0) begin bad++; $display("FAIL full_popaccept got=%b%b%b exp=110", vid_readdatavalid, sdr_read, vid_waitrequest); end
                step();
                @(negedge clk_50);
                total++; if (pend_cnt !== 4'd8 || acc_addr.size() != 9) begin bad++; $display("FAIL full_after pend=%0d acc=%0d exp=8/9", pend_cnt, acc_addr.size()); end
                total++; if (vid_waitrequest !== 1'b1) begin bad++; $display("FAIL full_restall got=%b exp=1", vid_waitrequest); end
                step();
                resp_budget = 1000000;
            end
        join
        repeat (14) step();
        total++; if (pend_cnt !== 4'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", pend_cnt); end
        total++; if (vid_log.size() != 10 || vid_log[9] !== fdat(24'h000409)) begin bad++; $display("FAIL full_data n=%0d got=%0h exp=%0h", vid_log.size(), vid_log[9], fdat(24'h000409)); end
    endtask

    task automatic test_stray();
        clear_logs();
        m_rdv = 1'b1;
        @(negedge clk_50);
        total++; if (vid_readdatavalid !== 1'b0 || cpu_readdatavalid !== 1'b0) begin bad++; $display("FAIL stray_rdv got=%b%b exp=00", vid_readdatavalid, cpu_readdatavalid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL stray_err_early got=%b exp=0", err); end
        step();
        m_rdv = 1'b0;
        @(negedge clk_50);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL stray_err got=%b exp=1", err); end
        repeat (3) step();
        @(negedge clk_50);
        total++; if (err !== 1'b1 || pend_cnt !== 4'd0) begin bad++; $display("FAIL stray_sticky err=%b pend=%0d exp=1/0", err, pend_cnt); end
        step();
    endtask

    task automatic test_reset_mid();
        clear_logs();
        lat = 20;
        vid_master(3, 24'h000500);
        @(negedge clk_50);
        total++; if (pend_cnt !== 4'd3) begin bad++; $display("FAIL rmid_pend got=%0d exp=3", pend_cnt); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk_50);
        total++; if (pend_cnt !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL rmid_clear pend=%0d err=%b exp=0/0", pend_cnt, err); end
        total++; if (vid_waitrequest !== 1'b1 || cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL rmid_idle got=%b%b exp=11", vid_waitrequest, cpu_waitrequest); end
        step();
        clear_logs();
        lat = 2;
        vid_master(1, 24'h000600);
        repeat (6) step();
        total++; if (vid_log.size() != 1 || vid_log[0] !== fdat(24'h000600)) begin bad++; $display("FAIL rmid_route n=%0d got=%0h exp=%0h", vid_log.size(), vid_log[0], fdat(24'h000600)); end
        total++; if (cpu_log.size() != 0 || err !== 1'b0) begin bad++; $display("FAIL rmid_clean cpu_n=%0d err=%b exp=0/0", cpu_log.size(), err); end
    endtask

    initial begin
        #1;
        test_reset();
        test_cpu_write();
        test_vid_reads();
        test_preempt();
        test_full();
        test_stray();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
